dragon_head_ctrl: RTL and testbench



---
 rtl/dragon_head_ctrl_pkg.sv | 35 +++
 rtl/dragon_head_ctrl_if.sv | 26 ++
 rtl/dragon_head_ctrl_vsync_tick_sync.sv | 29 ++
 rtl/dragon_head_ctrl.sv | 139 +++++++++++++
 tb/tb_dragon_head_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dragon_head_ctrl_pkg.sv
// Shared codes for the dragon head controller: state pulses, orientations,
// orien_pos field offsets, maximum body length and the GROW/RUN FSM encoding.
package dragon_pkg;

    typedef enum logic [1:0] {
        ST_MOVE = 2'b00,
        ST_HEAL = 2'b01,
        ST_HIT  = 2'b10,
        ST_IDLE = 2'b11
    } state_code_t;

    typedef enum logic [1:0] {
        OR_UP    = 2'b00,
        OR_RIGHT = 2'b01,
        OR_DOWN  = 2'b10,
        OR_LEFT  = 2'b11
    } orient_t;

    typedef enum logic {
        FSM_GROW = 1'b0,
        FSM_RUN  = 1'b1
    } fsm_t;

    localparam int unsigned ORIENT_MSB = 9;
    localparam int unsigned Y_LSB      = 4;
    localparam int unsigned X_LSB      = 0;

    localparam logic [2:0] MAX_LEN = 3'd7;

    // One tile toward the target; only called when cur differs from tgt.
    function automatic logic [3:0] step_toward(input logic [3:0] cur, input logic [3:0] tgt);
        return (cur < tgt) ? cur + 4'd1 : cur - 4'd1;
    endfunction

endpackage

// File: rtl/dragon_head_ctrl_if.sv
// Game-side bus of the dragon head controller: run/target/hit requests in,
// head word, frame counter, state pulses and body length out.
interface dragon_head_ctrl_if;

    logic       enable_i;
    logic [3:0] target_x_i;
    logic [3:0] target_y_i;
    logic       hit_i;
    logic [9:0] orien_pos_o;
    logic [5:0] move_cnt_o;
    logic [1:0] states_o;
    logic [2:0] length_o;

    // Game logic / player side.
    modport master (
        output enable_i, target_x_i, target_y_i, hit_i,
        input  orien_pos_o, move_cnt_o, states_o, length_o
    );

    // Dragon head controller side.
    modport slave (
        input  enable_i, target_x_i, target_y_i, hit_i,
        output orien_pos_o, move_cnt_o, states_o, length_o
    );

endinterface

// File: rtl/dragon_head_ctrl_vsync_tick_sync.sv
// Brings raw VGA vsync into the clk domain and emits a one-clk frame tick
// on its rising edge.
module vsync_tick_sync (
    input  logic clk,
    input  logic reset,
    input  logic vsync_i,
    output logic tick_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Two-flop synchroniser followed by a delay flop for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= vsync_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign tick_o = sync2_q & ~prev_q;

endmodule

// File: rtl/dragon_head_ctrl.sv
// Dragon head controller: steps the head toward the target once per move
// period, grows the body to INIT_LEN after reset, heals periodically and
// shrinks on hits.
// Optional macro DRAGON_HIT_STUN_EN: an accepted hit suppresses the next step.
module dragon_head_ctrl
    import dragon_pkg::*;
#(
    parameter int unsigned MOVE_PERIOD = 20,
    parameter int unsigned HEAL_STEPS  = 16,
    parameter int unsigned INIT_LEN    = 3,
    parameter int unsigned START_X     = 0,
    parameter int unsigned START_Y     = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vsync_i,
    dragon_head_ctrl_if.slave bus
);

    localparam logic [5:0] CNT_LAST  = 6'(MOVE_PERIOD - 1);
    localparam logic [7:0] HEAL_LAST = 8'(HEAL_STEPS - 1);
    localparam logic [2:0] LEN_INIT  = 3'(INIT_LEN);

    logic        tick;
    orient_t     orient_q;
    logic [3:0]  x_q;
    logic [3:0]  y_q;
    logic [5:0]  cnt_q;
    state_code_t st_q;
    logic [2:0]  len_q;
    fsm_t        fsm_q;
    logic [7:0]  step_cnt_q;
    logic        heal_pend_q;
    logic        wrap;
    logic        step_evt;
    logic        step_go;
    logic        hit_ok;

    vsync_tick_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .vsync_i (vsync_i),
        .tick_o  (tick)
    );

    assign wrap     = tick && (cnt_q == CNT_LAST);
    assign step_evt = wrap && (fsm_q == FSM_RUN) && bus.enable_i;
    assign hit_ok   = bus.hit_i && bus.enable_i && (fsm_q == FSM_RUN) && (len_q != 3'd0);

`ifdef DRAGON_HIT_STUN_EN
    logic stun_q;
    assign step_go = step_evt && !stun_q;

    // Stun flag: armed by an accepted hit, consumed by the next step event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stun_q <= 1'b0;
        end else if (hit_ok) begin
            stun_q <= 1'b1;
        end else if (step_evt) begin
            stun_q <= 1'b0;
        end
    end
`else
    assign step_go = step_evt;
`endif

    // Frame counter, GROW/RUN FSM, head position and registered state pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            orient_q    <= OR_UP;
            x_q         <= 4'(START_X);
            y_q         <= 4'(START_Y);
            cnt_q       <= '0;
            st_q        <= ST_IDLE;
            len_q       <= '0;
            fsm_q       <= FSM_GROW;
            step_cnt_q  <= '0;
            heal_pend_q <= 1'b0;
        end else begin
            if (tick) begin
                cnt_q <= wrap ? '0 : cnt_q + 6'd1;
            end
            case (fsm_q)
                FSM_GROW: begin
                    if (len_q == LEN_INIT) begin
                        fsm_q <= FSM_RUN;
                        st_q  <= ST_IDLE;
                    end else if (st_q == ST_HEAL) begin
                        st_q <= ST_IDLE;
                    end else begin
                        st_q  <= ST_HEAL;
                        len_q <= len_q + 3'd1;
                    end
                end
                default: begin
                    if (step_go) begin
                        if (x_q != bus.target_x_i) begin
                            x_q      <= step_toward(x_q, bus.target_x_i);
                            orient_q <= (bus.target_x_i > x_q) ? OR_RIGHT : OR_LEFT;
                        end else if (y_q != bus.target_y_i) begin
                            y_q      <= step_toward(y_q, bus.target_y_i);
                            orient_q <= (bus.target_y_i > y_q) ? OR_DOWN : OR_UP;
                        end
                        if (step_cnt_q == HEAL_LAST) begin
                            step_cnt_q  <= '0;
                            heal_pend_q <= 1'b1;
                        end else begin
                            step_cnt_q <= step_cnt_q + 8'd1;
                        end
                    end
                    // HIT > MOVE > HEAL; a heal that loses stays pending.
                    if (hit_ok) begin
                        st_q  <= ST_HIT;
                        len_q <= len_q - 3'd1;
                    end else if (step_go) begin
                        st_q <= ST_MOVE;
                    end else if (heal_pend_q) begin
                        heal_pend_q <= 1'b0;
                        if (len_q != MAX_LEN) begin
                            st_q  <= ST_HEAL;
                            len_q <= len_q + 3'd1;
                        end else begin
                            st_q <= ST_IDLE;
                        end
                    end else begin
                        st_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.orien_pos_o = {orient_q, y_q, x_q};
    assign bus.move_cnt_o  = cnt_q;
    assign bus.states_o    = st_q;
    assign bus.length_o    = len_q;

endmodule

// File: tb/tb_dragon_head_ctrl.sv
// Directed bench for dragon_head_ctrl with MOVE_PERIOD=3, HEAL_STEPS=2,
// INIT_LEN=3, start (0,0). Expected values are hand-computed constants.
module tb_dragon_head_ctrl;

    localparam logic [1:0] S_MOVE = 2'b00;
    localparam logic [1:0] S_HEAL = 2'b01;
    localparam logic [1:0] S_HIT  = 2'b10;
    localparam logic [1:0] S_IDLE = 2'b11;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic vsync_i = 1'b0;
    int   checks = 0;
    int   fails = 0;

    // Results captured by run_frame.
    logic [5:0] f_cnt2, f_cnt3;
    logic [1:0] f_st3, f_st4;
    logic [9:0] f_pos3;
    logic [2:0] f_len3, f_len4;

    dragon_head_ctrl_if bus();

    dragon_head_ctrl #(
        .MOVE_PERIOD (3),
        .HEAL_STEPS  (2),
        .INIT_LEN    (3),
        .START_X     (0),
        .START_Y     (0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .vsync_i (vsync_i),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // One vsync pulse; the tick-driven update lands on the 3rd posedge (p3).
    task automatic run_frame(input bit hit_at_tick);
        @(negedge clk) vsync_i = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        f_cnt2 = bus.move_cnt_o;
        @(negedge clk) bus.hit_i = hit_at_tick;
        @(posedge clk); #1;
        f_cnt3 = bus.move_cnt_o;
        f_st3  = bus.states_o;
        f_pos3 = bus.orien_pos_o;
        f_len3 = bus.length_o;
        @(negedge clk);
        bus.hit_i = 1'b0;
        vsync_i   = 1'b0;
        @(posedge clk); #1;
        f_st4  = bus.states_o;
        f_len4 = bus.length_o;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        bus.enable_i   = 1'b1;
        bus.target_x_i = 4'd0;
        bus.target_y_i = 4'd0;
        bus.hit_i      = 1'b0;
        reset          = 1'b1;
        #12;
        checks++;
        if (bus.orien_pos_o !== 10'h000) begin
            fails++; $display("FAIL reset_pos: got %h expected 000", bus.orien_pos_o);
        end
        checks++;
        if (bus.move_cnt_o !== 6'd0) begin
            fails++; $display("FAIL reset_cnt: got %0d expected 0", bus.move_cnt_o);
        end
        checks++;
        if (bus.states_o !== S_IDLE) begin
            fails++; $display("FAIL reset_state: got %b expected 11", bus.states_o);
        end
        checks++;
        if (bus.length_o !== 3'd0) begin
            fails++; $display("FAIL reset_len: got %0d expected 0", bus.length_o);
        end
    endtask

    task automatic test_grow();
        logic [2:0] exp_len [8] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3};
        logic [1:0] exp_st;
        @(negedge clk) reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            exp_st = (k == 1 || k == 3 || k == 5) ? S_HEAL : S_IDLE;
            checks++;
            if (bus.states_o !== exp_st) begin
                fails++; $display("FAIL grow_state clk%0d: got %b expected %b", k, bus.states_o, exp_st);
            end
            checks++;
            if (bus.length_o !== exp_len[k-1]) begin
                fails++; $display("FAIL grow_len clk%0d: got %0d expected %0d", k, bus.length_o, exp_len[k-1]);
            end
        end
    endtask

    // Counter runs with enable low; no MOVE pulses while disabled.
    task automatic test_counter();
        bus.enable_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            run_frame(1'b0);
            checks++;
            if (f_cnt2 !== 6'(i % 3)) begin
                fails++; $display("FAIL cnt_before frame%0d: got %0d expected %0d", i, f_cnt2, i % 3);
            end
            checks++;
            if (f_cnt3 !== 6'((i + 1) % 3)) begin
                fails++; $display("FAIL cnt_after frame%0d: got %0d expected %0d", i, f_cnt3, (i + 1) % 3);
            end
            checks++;
            if (f_st3 !== S_IDLE) begin
                fails++; $display("FAIL cnt_disabled_state frame%0d: got %b expected 11", i, f_st3);
            end
        end
    endtask

    task automatic test_pathing();
        logic [9:0] exp_pos [4] = '{10'h101, 10'h102, 10'h212, 10'h212};
        logic [1:0] exp_st4 [4] = '{S_IDLE, S_HEAL, S_IDLE, S_HEAL};
        logic [2:0] exp_len [4] = '{3'd3, 3'd4, 3'd4, 3'd5};
        bus.enable_i   = 1'b1;
        bus.target_x_i = 4'd2;
        bus.target_y_i = 4'd1;
        for (int s = 0; s < 4; s++) begin
            repeat (2) begin
                run_frame(1'b0);
                checks++;
                if (f_st3 !== S_IDLE) begin
                    fails++; $display("FAIL path_quiet step%0d: got %b expected 11", s + 1, f_st3);
                end
            end
            run_frame(1'b0);
            checks++;
            if (f_st3 !== S_MOVE) begin
                fails++; $display("FAIL path_move step%0d: got %b expected 00", s + 1, f_st3);
            end
            checks++;
            if (f_pos3 !== exp_pos[s]) begin
                fails++; $display("FAIL path_pos step%0d: got %h expected %h", s + 1, f_pos3, exp_pos[s]);
            end
            checks++;
            if (f_st4 !== exp_st4[s] || f_len4 !== exp_len[s]) begin
                fails++; $display("FAIL path_heal step%0d: got %b/%0d expected %b/%0d", s + 1, f_st4, f_len4, exp_st4[s], exp_len[s]);
            end
        end
    endtask

    task automatic test_hit_disabled();
        bus.target_x_i = 4'd4;
        bus.enable_i   = 1'b0;
        @(negedge clk) bus.hit_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.states_o !== S_IDLE || bus.length_o !== 3'd5) begin
            fails++; $display("FAIL hit_disabled: got %b/%0d expected 11/5", bus.states_o, bus.length_o);
        end
        @(negedge clk);
        bus.hit_i    = 1'b0;
        bus.enable_i = 1'b1;
    endtask

    task automatic test_hit();
        @(negedge clk) bus.hit_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.states_o !== S_HIT || bus.length_o !== 3'd4) begin
            fails++; $display("FAIL hit_accept: got %b/%0d expected 10/4", bus.states_o, bus.length_o);
        end
        @(negedge clk) bus.hit_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.states_o !== S_IDLE) begin
            fails++; $display("FAIL hit_width: got %b expected 11", bus.states_o);
        end
    endtask

    task automatic test_after_hit();
`ifdef DRAGON_HIT_STUN_EN
        repeat (3) run_frame(1'b0);
        checks++;
        if (f_st3 !== S_IDLE || f_pos3 !== 10'h212) begin
            fails++; $display("FAIL stun_suppress: got %b/%h expected 11/212", f_st3, f_pos3);
        end
`endif
        repeat (3) run_frame(1'b0);
        checks++;
        if (f_st3 !== S_MOVE || f_pos3 !== 10'h113) begin
            fails++; $display("FAIL after_hit_step: got %b/%h expected 00/113", f_st3, f_pos3);
        end
        checks++;
        if (f_st4 !== S_IDLE) begin
            fails++; $display("FAIL after_hit_noheal: got %b expected 11", f_st4);
        end
    endtask

    task automatic test_collision();
        repeat (2) run_frame(1'b0);
        run_frame(1'b1);
        checks++;
        if (f_st3 !== S_HIT || f_len3 !== 3'd3) begin
            fails++; $display("FAIL coll_hit: got %b/%0d expected 10/3", f_st3, f_len3);
        end
        checks++;
        if (f_pos3 !== 10'h114) begin
            fails++; $display("FAIL coll_pos: got %h expected 114", f_pos3);
        end
        checks++;
        if (f_st4 !== S_HEAL || f_len4 !== 3'd4) begin
            fails++; $display("FAIL coll_heal: got %b/%0d expected 01/4", f_st4, f_len4);
        end
    endtask

    task automatic test_saturation();
        logic [2:0] exp_len [10] = '{3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
        logic [1:0] exp_st4;
`ifdef DRAGON_HIT_STUN_EN
        repeat (3) run_frame(1'b0);
        checks++;
        if (f_st3 !== S_IDLE || f_pos3 !== 10'h114) begin
            fails++; $display("FAIL stun_after_coll: got %b/%h expected 11/114", f_st3, f_pos3);
        end
`endif
        for (int k = 1; k <= 10; k++) begin
            repeat (3) run_frame(1'b0);
            exp_st4 = (k == 2 || k == 4 || k == 6) ? S_HEAL : S_IDLE;
            checks++;
            if (f_st3 !== S_MOVE || f_pos3 !== 10'h114) begin
                fails++; $display("FAIL sat_hold step%0d: got %b/%h expected 00/114", k, f_st3, f_pos3);
            end
            checks++;
            if (f_st4 !== exp_st4 || f_len4 !== exp_len[k-1]) begin
                fails++; $display("FAIL sat_heal step%0d: got %b/%0d expected %b/%0d", k, f_st4, f_len4, exp_st4, exp_len[k-1]);
            end
        end
    endtask

    task automatic test_zero_length();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) bus.hit_i = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (i < 7) begin
                if (bus.states_o !== S_HIT || bus.length_o !== 3'(6 - i)) begin
                    fails++; $display("FAIL zero_drain hit%0d: got %b/%0d expected 10/%0d", i, bus.states_o, bus.length_o, 6 - i);
                end
            end else begin
                if (bus.states_o !== S_IDLE || bus.length_o !== 3'd0) begin
                    fails++; $display("FAIL zero_ignore: got %b/%0d expected 11/0", bus.states_o, bus.length_o);
                end
            end
            @(negedge clk) bus.hit_i = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.orien_pos_o !== 10'h000 || bus.move_cnt_o !== 6'd0 ||
            bus.states_o !== S_IDLE || bus.length_o !== 3'd0) begin
            fails++; $display("FAIL reset_mid: got %h/%0d/%b/%0d expected 000/0/11/0",
                              bus.orien_pos_o, bus.move_cnt_o, bus.states_o, bus.length_o);
        end
    endtask

    initial begin
        test_reset();
        test_grow();
        test_counter();
        test_pathing();
        test_hit_disabled();
        test_hit();
        test_after_hit();
        test_collision();
        test_saturation();
        test_zero_length();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
